// File: rtl/micro_sequencer_if.sv
// Bus between the micro_sequencer and its environment: opcode/flags/stall in,
// control-store address and microword, decoded strobes and status out.
interface micro_sequencer_if #(
  parameter int AW          = 8,
  parameter int OPW         = 7,
  parameter int STACK_DEPTH = 4
);
  localparam int UW  = AW + 24;
  localparam int SPW = $clog2(STACK_DEPTH + 1);

  logic [OPW-1:0] i_opcode;
  logic           i_n;
  logic           i_z;
  logic           i_v;
  logic           i_c;
  logic           i_hold;
  logic [UW-1:0]  i_uword;
  logic [AW-1:0]  o_uaddr;
  logic [AW-1:0]  o_upc;
  logic [AW-1:0]  o_na;
  logic           o_cond;
  logic           o_il;
  logic           o_pi;
  logic           o_pl;
  logic           o_mb;
  logic           o_md;
  logic           o_rw;
  logic           o_mm;
  logic           o_mw;
  logic           o_valid;
  logic           o_err;
  logic [SPW-1:0] o_sp;

  modport master (
    input  i_opcode, i_n, i_z, i_v, i_c, i_hold, i_uword,
    output o_uaddr, o_upc, o_na, o_cond,
           o_il, o_pi, o_pl, o_mb, o_md, o_rw, o_mm, o_mw,
           o_valid, o_err, o_sp
  );

  modport slave (
    output i_opcode, i_n, i_z, i_v, i_c, i_hold, i_uword,
    input  o_uaddr, o_upc, o_na, o_cond,
           o_il, o_pi, o_pl, o_mb, o_md, o_rw, o_mm, o_mw,
           o_valid, o_err, o_sp
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: next-address select (sequential / conditional jump /
// opcode dispatch) and strobe decode. Define MICRO_SEQ_STACK_EN for call/return.
module micro_sequencer #(
  parameter int            AW          = 8,
  parameter int            OPW         = 7,
  parameter logic [AW-1:0] MAP_BASE    = {AW{1'b0}},
  parameter logic [AW-1:0] RESET_ADDR  = {AW{1'b0}},
  parameter int            STACK_DEPTH = 4
) (
  input logic               i_clk,
  input logic               i_rstn,
  micro_sequencer_if.master bus
);
  localparam int UW  = AW + 24;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [AW-1:0]  UPC_ONE  = AW'(1);
  localparam logic [SPW-1:0] SP_ZERO  = {SPW{1'b0}};
  localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL  = SPW'(STACK_DEPTH);
  localparam logic [1:0]     SQ_CALL  = 2'b01;
  localparam logic [1:0]     SQ_RET   = 2'b10;
`ifdef MICRO_SEQ_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_MAP  = 3'd1,
    SEL_RET  = 3'd2,
    SEL_JUMP = 3'd3,
    SEL_SEQ  = 3'd4
  } sel_e;

  logic [AW-1:0]  upc_q, upc_d;
  logic           valid_q, valid_d;
  logic [1:0]     sq_s;
  logic [AW-1:0]  na_s;
  logic [2:0]     ms_s;
  logic           mc_s;
  logic           cond_s;
  logic           gate_s;
  logic [AW-1:0]  op_ext_s;
  logic [AW-1:0]  upc_inc_s;
  logic [AW-1:0]  uaddr_s;
  logic [AW-1:0]  stack_top_s;
  logic [SPW-1:0] sp_s;
  logic           err_s;
  logic           sp_empty_s;
  sel_e           sel_s;

  assign sq_s       = bus.i_uword[UW-1:UW-2];
  assign na_s       = bus.i_uword[AW+19:20];
  assign ms_s       = bus.i_uword[19:17];
  assign mc_s       = bus.i_uword[16];
  assign upc_inc_s  = upc_q + UPC_ONE;
  assign sp_empty_s = (sp_s == SP_ZERO);
  assign gate_s     = valid_q & ~bus.i_hold;

  // Opcode is zero-extended or truncated to the address width before dispatch.
  generate
    if (OPW >= AW) begin : g_op_trunc
      assign op_ext_s = bus.i_opcode[AW-1:0];
    end else begin : g_op_zext
      assign op_ext_s = {{(AW-OPW){1'b0}}, bus.i_opcode};
    end
  endgenerate

  // Condition multiplexer driven by the MS field.
  always_comb begin
    cond_s = 1'b0;
    case (ms_s)
      3'd0:    cond_s = 1'b0;
      3'd1:    cond_s = 1'b1;
      3'd2:    cond_s = bus.i_c;
      3'd3:    cond_s = bus.i_v;
      3'd4:    cond_s = bus.i_z;
      3'd5:    cond_s = bus.i_n;
      3'd6:    cond_s = ~bus.i_z;
      3'd7:    cond_s = ~bus.i_n;
      default: cond_s = 1'b0;
    endcase
  end

  // Next-address source selection in priority order.
  always_comb begin
    sel_s = SEL_HOLD;
    if (!valid_q || bus.i_hold) begin
      sel_s = SEL_HOLD;
    end else if (mc_s) begin
      sel_s = SEL_MAP;
    end else if (STACK_EN && (sq_s == SQ_RET)) begin
      sel_s = SEL_RET;
    end else if (cond_s) begin
      sel_s = SEL_JUMP;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next-address mux; an empty-stack return restarts at RESET_ADDR.
  always_comb begin
    uaddr_s = upc_q;
    case (sel_s)
      SEL_HOLD: uaddr_s = upc_q;
      SEL_MAP:  uaddr_s = MAP_BASE + op_ext_s;
      SEL_RET:  uaddr_s = sp_empty_s ? RESET_ADDR : stack_top_s;
      SEL_JUMP: uaddr_s = na_s;
      SEL_SEQ:  uaddr_s = upc_inc_s;
      default:  uaddr_s = upc_q;
    endcase
  end

  // Sequencer state update; valid rises after the one-cycle fill.
  always_comb begin
    upc_d   = uaddr_s;
    valid_d = 1'b1;
  end

  // Microprogram counter and valid flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      upc_q   <= RESET_ADDR;
      valid_q <= 1'b0;
    end else begin
      upc_q   <= upc_d;
      valid_q <= valid_d;
    end
  end

`ifdef MICRO_SEQ_STACK_EN
  logic [AW-1:0]  stack_q [STACK_DEPTH];
  logic [AW-1:0]  stack_d [STACK_DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           sp_full_s;
  logic           is_call_s;
  logic           push_s;
  logic           pop_s;
  logic           fault_s;

  assign sp_full_s = (sp_q == SP_FULL);
  assign is_call_s = (sel_s == SEL_JUMP) && (sq_s == SQ_CALL);

  // Push on a taken CALL, pop on RET; overflow/underflow raise the fault.
  always_comb begin
    push_s  = is_call_s && !sp_full_s;
    pop_s   = (sel_s == SEL_RET) && !sp_empty_s;
    fault_s = (is_call_s && sp_full_s) || ((sel_s == SEL_RET) && sp_empty_s);
  end

  // Top-of-stack read selected by occupancy.
  always_comb begin
    stack_top_s = {AW{1'b0}};
    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_top_s = (sp_q == SPW'(i + 1)) ? stack_q[i] : stack_top_s;
    end
  end

  // Stack storage, pointer and sticky fault next-state.
  always_comb begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_d[i] = (push_s && (sp_q == SPW'(i))) ? upc_inc_s : stack_q[i];
    end
    case ({push_s, pop_s})
      2'b10:   sp_d = sp_q + SP_ONE;
      2'b01:   sp_d = sp_q - SP_ONE;
      default: sp_d = sp_q;
    endcase
    err_d = err_q | fault_s;
  end

  // Stack registers; reset discards all contents immediately.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= {AW{1'b0}};
      end
      sp_q  <= SP_ZERO;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign sp_s  = sp_q;
  assign err_s = err_q;
`else
  assign stack_top_s = {AW{1'b0}};
  assign sp_s        = SP_ZERO;
  assign err_s       = 1'b0;
`endif

  assign bus.o_uaddr = uaddr_s;
  assign bus.o_upc   = upc_q;
  assign bus.o_na    = na_s;
  assign bus.o_cond  = cond_s;
  assign bus.o_valid = valid_q;
  assign bus.o_err   = err_s;
  assign bus.o_sp    = sp_s;
  assign bus.o_il    = bus.i_uword[15] & gate_s;
  assign bus.o_pi    = bus.i_uword[14] & gate_s;
  assign bus.o_pl    = bus.i_uword[13] & gate_s;
  assign bus.o_mb    = bus.i_uword[9]  & gate_s;
  assign bus.o_md    = bus.i_uword[3]  & gate_s;
  assign bus.o_rw    = bus.i_uword[2]  & gate_s;
  assign bus.o_mm    = bus.i_uword[1]  & gate_s;
  assign bus.o_mw    = bus.i_uword[0]  & gate_s;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a behavioural synchronous-read control
// store; expectations adapt to whether MICRO_SEQ_STACK_EN is defined.
module tb_micro_sequencer;
  localparam int AW  = 8;
  localparam int OPW = 7;
  localparam int SD  = 4;
  localparam logic [15:0] S_IL = 16'h8000;
  localparam logic [15:0] S_MW = 16'h0001;
  localparam logic [15:0] S_NONE = 16'h0000;

  logic        clk;
  logic        rstn;
  logic [31:0] mem [256];
  logic [7:0]  strb;
  int          total;
  int          bad;

  micro_sequencer_if #(.AW(AW), .OPW(OPW), .STACK_DEPTH(SD)) bus ();

  micro_sequencer #(
    .AW(AW), .OPW(OPW), .MAP_BASE(8'h80), .RESET_ADDR(8'h00), .STACK_DEPTH(SD)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.i_uword <= mem[bus.o_uaddr];

  assign strb = {bus.o_il, bus.o_pi, bus.o_pl, bus.o_mb,
                 bus.o_md, bus.o_rw, bus.o_mm, bus.o_mw};

  function automatic logic [31:0] uw(input logic [1:0] sq, input logic [7:0] na,
                                     input logic [2:0] ms, input logic mc,
                                     input logic [15:0] s);
    uw = {sq, 2'b00, na, ms, mc, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = uw(2'b00, 8'h00, 3'd0, 1'b0, S_IL);
    mem[8'h05] = uw(2'b00, 8'h40, 3'd4, 1'b0, S_NONE);
    mem[8'h40] = uw(2'b00, 8'h05, 3'd1, 1'b0, S_NONE);
    mem[8'h06] = uw(2'b00, 8'h00, 3'd0, 1'b1, S_NONE);
    mem[8'h85] = uw(2'b00, 8'hFF, 3'd1, 1'b0, S_NONE);
    mem[8'h10] = uw(2'b01, 8'h30, 3'd1, 1'b0, S_NONE);
    mem[8'h30] = uw(2'b10, 8'h00, 3'd0, 1'b0, S_NONE);
    mem[8'h31] = uw(2'b00, 8'h11, 3'd1, 1'b0, S_NONE);
    mem[8'h11] = uw(2'b00, 8'h00, 3'd0, 1'b0, S_MW);
    for (int a = 8'h12; a <= 8'h16; a++) mem[a] = uw(2'b01, 8'(a + 1), 3'd1, 1'b0, S_NONE);
    mem[8'h17] = uw(2'b01, 8'h50, 3'd0, 1'b0, S_NONE);

    rstn = 1'b0;
    bus.i_opcode = 7'h05;
    bus.i_n = 1'b0; bus.i_z = 1'b0; bus.i_v = 1'b0; bus.i_c = 1'b0;
    bus.i_hold = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_uaddr", 32'(bus.o_uaddr), 32'h00);
    chk("rst_upc",   32'(bus.o_upc),   32'h00);
    chk("rst_sp",    32'(bus.o_sp),    32'h0);
    chk("rst_err",   32'(bus.o_err),   32'h0);
    chk("rst_strb",  32'(strb),        32'h00);
    rstn = 1'b1;

    tick();
    chk("fill_valid", 32'(bus.o_valid), 32'h1);
    chk("fill_upc",   32'(bus.o_upc),   32'h00);
    chk("seq_uaddr1", 32'(bus.o_uaddr), 32'h01);
    chk("fill_il",    32'(strb),        32'h80);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("seq_upc",   32'(bus.o_upc),   32'(k));
      chk("seq_uaddr", 32'(bus.o_uaddr), 32'(k + 1));
    end
    chk("seq_strb", 32'(strb), 32'h00);
    tick();
    bus.i_z = 1'b1;
    tick();
    chk("cz1_upc",   32'(bus.o_upc),   32'h05);
    chk("cz1_cond",  32'(bus.o_cond),  32'h1);
    chk("cz1_na",    32'(bus.o_na),    32'h40);
    tick();
    chk("cz1_jump",  32'(bus.o_upc),   32'h40);
    bus.i_z = 1'b0;
    tick();
    chk("cz0_cond",  32'(bus.o_cond),  32'h0);
    chk("cz0_uaddr", 32'(bus.o_uaddr), 32'h06);
    tick();
    chk("cz0_upc",   32'(bus.o_upc),   32'h06);
    chk("map_uaddr", 32'(bus.o_uaddr), 32'h85);
    mem[8'h00] = uw(2'b00, 8'h10, 3'd1, 1'b0, S_IL);
    tick();
    chk("map_upc",   32'(bus.o_upc),   32'h85);
    tick();
    chk("wrap_uaddr", 32'(bus.o_uaddr), 32'h00);
    tick();
    chk("wrap_upc",  32'(bus.o_upc),   32'h00);
    tick();
    chk("call_upc",  32'(bus.o_upc),   32'h10);
    tick();
    chk("call_tgt",  32'(bus.o_upc),   32'h30);
`ifdef MICRO_SEQ_STACK_EN
    chk("call_sp",   32'(bus.o_sp),    32'h1);
    tick();
    chk("ret_upc",   32'(bus.o_upc),   32'h11);
    chk("ret_sp",    32'(bus.o_sp),    32'h0);
`else
    chk("call_sp",   32'(bus.o_sp),    32'h0);
    tick();
    chk("ret_next",  32'(bus.o_upc),   32'h31);
    tick();
    chk("ret_upc",   32'(bus.o_upc),   32'h11);
`endif
    chk("mw_pre", 32'(strb), 32'h01);
    bus.i_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_uaddr", 32'(bus.o_uaddr), 32'h11);
      chk("hold_mw",    32'(bus.o_mw),    32'h0);
      tick();
      chk("hold_upc",   32'(bus.o_upc),   32'h11);
    end
    bus.i_hold = 1'b0;
    #1;
    chk("rel_uaddr", 32'(bus.o_uaddr), 32'h12);
    chk("rel_mw",    32'(bus.o_mw),    32'h1);
    tick();
    chk("rel_upc",   32'(bus.o_upc),   32'h12);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("nest_upc", 32'(bus.o_upc), 32'(8'h12 + k));
`ifdef MICRO_SEQ_STACK_EN
      chk("nest_sp",  32'(bus.o_sp),  32'(k));
`else
      chk("nest_sp",  32'(bus.o_sp),  32'h0);
`endif
      chk("nest_err", 32'(bus.o_err), 32'h0);
    end
    tick();
    chk("ovf_upc", 32'(bus.o_upc), 32'h17);
`ifdef MICRO_SEQ_STACK_EN
    chk("ovf_sp",  32'(bus.o_sp),  32'h4);
    chk("ovf_err", 32'(bus.o_err), 32'h1);
`else
    chk("ovf_sp",  32'(bus.o_sp),  32'h0);
    chk("ovf_err", 32'(bus.o_err), 32'h0);
`endif
    tick();
    chk("call0_upc", 32'(bus.o_upc), 32'h18);
`ifdef MICRO_SEQ_STACK_EN
    chk("call0_sp",  32'(bus.o_sp),  32'h4);
`else
    chk("call0_sp",  32'(bus.o_sp),  32'h0);
`endif

    mem[8'h00] = uw(2'b10, 8'h00, 3'd0, 1'b0, S_NONE);
    rstn = 1'b0;
    #1;
    chk("arst_sp",    32'(bus.o_sp),    32'h0);
    chk("arst_err",   32'(bus.o_err),   32'h0);
    chk("arst_valid", 32'(bus.o_valid), 32'h0);
    chk("arst_uaddr", 32'(bus.o_uaddr), 32'h00);
    tick();
    rstn = 1'b1;
    tick();
    chk("eret_upc", 32'(bus.o_upc), 32'h00);
`ifdef MICRO_SEQ_STACK_EN
    chk("eret_uaddr", 32'(bus.o_uaddr), 32'h00);
    tick();
    chk("eret_err",  32'(bus.o_err), 32'h1);
    chk("eret_upc2", 32'(bus.o_upc), 32'h00);
    tick();
    chk("eret_sticky", 32'(bus.o_err), 32'h1);
`else
    chk("eret_uaddr", 32'(bus.o_uaddr), 32'h01);
    tick();
    chk("eret_err",  32'(bus.o_err), 32'h0);
    chk("eret_upc2", 32'(bus.o_upc), 32'h01);
    tick();
    chk("eret_upc3", 32'(bus.o_upc), 32'h02);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised microprogram sequencer for the microprogrammed CPU. It drives the address port of an external synchronous-read control store and decodes the returned microword into datapath strobes. Next-address selection supports sequential, conditional jump, and opcode-mapped dispatch. An optional microcode call/return stack provides subroutines. It sits between the instruction register (opcode source), the ALU flags, and the control store.

## Interface
- AW, 8: control-store address width. Microword width UW = AW+24 (localparam).
- OPW, 7: opcode width.
- MAP_BASE, 0: AW-bit base added to the opcode for dispatch.
- RESET_ADDR, 0: microaddress loaded at reset.
- STACK_DEPTH, 4: return-stack entries, at least 1. SPW = $clog2(STACK_DEPTH+1).
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_opcode  in  OPW  opcode from the instruction register.
- i_n, i_z, i_v, i_c  in  1 each  ALU status flags.
- i_hold  in  1  stall; freezes sequencing.
- i_uword  in  UW  control-store read data, one cycle after o_uaddr.
- o_uaddr  out  AW  combinational next address to the control store.
- o_upc  out  AW  address of the word currently on i_uword.
- o_na  out  AW  NA field of the current word.
- o_cond  out  1  selected condition (for the macro PC branch).
- o_il, o_pi, o_pl, o_mb, o_md, o_rw, o_mm, o_mw  out  1 each  gated strobes.
- o_valid  out  1  current microword valid.
- o_err  out  1  sticky stack fault.
- o_sp  out  SPW  stack occupancy.

## Operation
- Microword fields:
  - SQ[UW-1:UW-2]: 00 = NEXT, 01 = CALL, 10 = RET, 11 = NEXT.
  - [UW-3:UW-4] reserved.
  - NA[AW+19:20], MS[19:17], MC[16], IL[15], PI[14], PL[13], MB[9], MD[3], RW[2], MM[1], MW[0].
- Condition from MS: 0 false, 1 true, 2 C, 3 V, 4 Z, 5 N, 6 !Z, 7 !N.
- Next-address priority (when o_valid=1 and i_hold=0):
  1. MC=1: MAP_BASE + zero-extended i_opcode (truncated to AW, mod 2^AW).
  2. SQ=RET: pop the stack top. If the stack is empty, go to RESET_ADDR and set o_err.
  3. cond=1: go to NA. If SQ=CALL, also push upc+1. If the stack is full, the push is dropped, o_err is set, and the jump still occurs.
  4. Otherwise: upc+1, wrapping modulo 2^AW.
- CALL with cond=0 does not push.
- i_hold=1 or o_valid=0: o_uaddr=o_upc (re-read the same word), and the stack is unchanged.
- Strobes = field AND o_valid AND !i_hold.
- o_cond and o_na are ungated.
- o_err clears only on reset.

## Timing
- Reset values:
  - upc = RESET_ADDR, o_uaddr = RESET_ADDR.
  - o_valid = 0, o_err = 0, o_sp = 0, stack cleared.
  - All strobes 0.
- o_valid rises on the first i_clk edge after reset deassertion (one-cycle fill). i_uword is then the word at RESET_ADDR.
- Each clock edge: upc <= o_uaddr. The word at the new upc appears on i_uword the same cycle, so there is one microinstruction per cycle.
- Stack push/pop and o_sp update on the same edge as upc.
- Reset asserted mid-call discards all stack contents immediately (asynchronous).

## Configuration
- MICRO_SEQ_STACK_EN defined: CALL/RET stack as above.
- Not defined:
  - CALL behaves as NEXT, and RET behaves as NEXT.
  - No stack storage.
  - o_sp and o_err are tied to 0.

## Test plan
- Reset, then release, with words at 0..3 all SQ=00, MS=0, MC=0 → o_uaddr 1,2,3,4 on consecutive cycles. o_valid=1 from the first edge. All strobes 0 during reset.
- Word at 5: MS=4, NA=0x40. With i_z=1 → next o_upc=0x40. With i_z=0 → 0x06.
- MC=1, MAP_BASE=0x80, i_opcode=0x05 → next o_upc=0x85. Word at upc=0xFF with MS=0, MC=0 → next upc=0x00 (wrap).
- CALL from 0x10 (MS=1, NA=0x30), then RET at 0x30 → upc 0x30 then 0x11, o_sp 1→0. A fifth nested CALL with depth 4 → o_err=1, o_sp stays 4, the jump is taken.
- RET with an empty stack → next upc=RESET_ADDR, o_err=1 and stays 1.
- i_hold=1 for 3 cycles on a word with MW=1 → o_uaddr=o_upc and o_mw=0 throughout; sequencing resumes unchanged on release.
